// File: rtl/alu_cu_gen.sv
// alu_cu_gen: sequencing control unit for the WIDTH-bit A/Q/Q_1/M ALU datapath.
// Decodes OP and steps through add/sub, radix-2 Booth multiply and
// non-restoring divide, issuing one-hot control strobes per state.
// Optional feature macro: ALU_CU_DIVZERO_EN (early exit with ERR on divide by zero).
//
// Handshake: BGN is a level. In IDLE a sampled BGN=1 latches OP and starts a
// run; BGN is ignored while BUSY. On completion the unit sits in DONE with
// END=1 for as long as BGN stays high, and returns to IDLE on the first edge
// that samples BGN=0, so every run needs BGN to drop before the next start.
`timescale 1ns/1ps
module alu_cu_gen #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          BGN,
    input  logic [1:0]    OP,
    input  logic          Q0,
    input  logic          Q_1,
    input  logic          A_MSB,
    input  logic          M_ZERO,
    output logic          c0,
    output logic          c2,
    output logic          c3,
    output logic          c4,
    output logic          c5,
    output logic          c6,
    output logic          c9,
    output logic          QBIT,
    output logic          c7,
    output logic          c8,
    output logic [CW-1:0] CNT,
    output logic          BUSY,
    output logic          END,
    output logic          ERR,
    output logic [3:0]    state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_M = 4'd2,
        S_EXEC   = 4'd3,
        S_B_TEST = 4'd4,
        S_B_SHR  = 4'd5,
        S_D_SHL  = 4'd6,
        S_D_STEP = 4'd7,
        S_D_SETQ = 4'd8,
        S_D_CORR = 4'd9,
        S_OUT_A  = 4'd10,
        S_OUT_Q  = 4'd11,
        S_DONE   = 4'd12
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [1:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic          sgn_q;
    logic          div_zero;
    logic          cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

`ifdef ALU_CU_DIVZERO_EN
    logic err_q;

    assign div_zero = (op_q == 2'b11) && M_ZERO;

    // Divide-by-zero flag: set on the early exit, dropped when DONE is left.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else if (state == S_LOAD_M) begin
            err_q <= div_zero;
        end else if (state == S_DONE && !BGN) begin
            err_q <= 1'b0;
        end
    end

    assign ERR = err_q && (state == S_DONE);
`else
    logic unused_m_zero;

    assign unused_m_zero = M_ZERO;
    assign div_zero      = 1'b0;
    assign ERR           = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Opcode latch, step counter (saturates at WIDTH-1) and divide sign bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q  <= 2'b00;
            cnt_q <= '0;
            sgn_q <= 1'b0;
        end else begin
            if (state == S_IDLE && BGN) begin
                op_q <= OP;
            end
            if (state == S_LOAD_A) begin
                cnt_q <= '0;
            end else if ((state == S_B_SHR || state == S_D_SETQ) && !cnt_last) begin
                cnt_q <= cnt_q + CW'(1);
            end
            // Sign of the partial remainder before the shift picks add or subtract.
            if (state == S_D_SHL) begin
                sgn_q <= A_MSB;
            end
        end
    end

    // Next-state and strobe decode; strobes depend on the registered state only
    // (plus the datapath status bits inside the Booth test and divide steps).
    always_comb begin
        state_nx = state;
        c0       = 1'b0;
        c2       = 1'b0;
        c3       = 1'b0;
        c4       = 1'b0;
        c5       = 1'b0;
        c6       = 1'b0;
        c9       = 1'b0;
        QBIT     = 1'b0;
        c7       = 1'b0;
        c8       = 1'b0;
        case (state)
            S_IDLE: begin
                if (BGN) state_nx = S_LOAD_A;
            end
            S_LOAD_A: begin
                c0       = 1'b1;
                state_nx = S_LOAD_M;
            end
            S_LOAD_M: begin
                c2 = 1'b1;
                if (div_zero) begin
                    state_nx = S_DONE;
                end else begin
                    case (op_q)
                        2'b00:   state_nx = S_EXEC;
                        2'b01:   state_nx = S_EXEC;
                        2'b10:   state_nx = S_B_TEST;
                        default: state_nx = S_D_SHL;
                    endcase
                end
            end
            S_EXEC: begin
                c3       = ~op_q[0];
                c4       = op_q[0];
                state_nx = S_OUT_A;
            end
            S_B_TEST: begin
                c4       = Q0 & ~Q_1;
                c3       = ~Q0 & Q_1;
                state_nx = S_B_SHR;
            end
            S_B_SHR: begin
                c5       = 1'b1;
                state_nx = cnt_last ? S_OUT_A : S_B_TEST;
            end
            S_D_SHL: begin
                c6       = 1'b1;
                state_nx = S_D_STEP;
            end
            S_D_STEP: begin
                c3       = sgn_q;
                c4       = ~sgn_q;
                state_nx = S_D_SETQ;
            end
            S_D_SETQ: begin
                c9       = 1'b1;
                QBIT     = ~A_MSB;
                state_nx = cnt_last ? S_D_CORR : S_D_SHL;
            end
            S_D_CORR: begin
                c3       = A_MSB;
                state_nx = S_OUT_A;
            end
            S_OUT_A: begin
                c7       = 1'b1;
                state_nx = op_q[1] ? S_OUT_Q : S_DONE;
            end
            S_OUT_Q: begin
                c8       = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                if (!BGN) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign CNT       = cnt_q;
    assign BUSY      = (state != S_IDLE) && (state != S_DONE);
    assign END       = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_cu_gen.sv
// tb_alu_cu_gen: scoreboard bench for alu_cu_gen at WIDTH=8.
// A trace model turns an opcode plus per-cycle datapath status bits into the
// cycle-by-cycle strobe/status vectors the control unit must present; a
// monitor pops one vector per cycle in which BUSY or END is high.
`timescale 1ns/1ps
module tb_alu_cu_gen;

    localparam int W  = 8;
    localparam int CW = $clog2(W);
    localparam int NC = 256;

    typedef struct packed {
        logic c0, c2, c3, c4, c5, c6, c9, qbit, c7, c8, busy, done, err;
        logic [CW-1:0] cnt;
    } vec_t;

    localparam int VW = $bits(vec_t);

    logic          CLK, RST, BGN, Q0, Q_1, A_MSB, M_ZERO;
    logic [1:0]    OP;
    logic          c0, c2, c3, c4, c5, c6, c9, QBIT, c7, c8, BUSY, END, ERR;
    logic [CW-1:0] CNT;
    logic [3:0]    state_dbg;

    logic [VW-1:0] exp_q[$];
    vec_t          trace[$];
    logic          tq0 [NC];
    logic          tq1 [NC];
    logic          tam [NC];
    logic          tmz [NC];
    logic [CW-1:0] model_cnt;
    int            vectors;
    int            miscompares;

    alu_cu_gen #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .BGN(BGN), .OP(OP), .Q0(Q0), .Q_1(Q_1),
        .A_MSB(A_MSB), .M_ZERO(M_ZERO), .c0(c0), .c2(c2), .c3(c3), .c4(c4),
        .c5(c5), .c6(c6), .c9(c9), .QBIT(QBIT), .c7(c7), .c8(c8), .CNT(CNT),
        .BUSY(BUSY), .END(END), .ERR(ERR), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t sample();
        vec_t v;
        v = {c0, c2, c3, c4, c5, c6, c9, QBIT, c7, c8, BUSY, END, ERR, CNT};
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Expected vector per cycle, from the LOAD_A cycle through the last DONE cycle.
    task automatic build_trace(input logic [1:0] op, input int hold);
        vec_t          v;
        int            k;
        logic [CW-1:0] cnt;
        logic          sgn;
        logic          dz;
        trace.delete();
        k = 0;
        v = '0; v.c0 = 1'b1; v.busy = 1'b1; v.cnt = model_cnt;
        trace.push_back(v); k++;
        cnt = '0;
        v = '0; v.c2 = 1'b1; v.busy = 1'b1; v.cnt = cnt;
        trace.push_back(v);
        dz = 1'b0;
`ifdef ALU_CU_DIVZERO_EN
        dz = (op == 2'b11) && tmz[k];
`endif
        k++;
        if (!dz) begin
            if (op == 2'b00 || op == 2'b01) begin
                v = '0; v.busy = 1'b1; v.cnt = cnt;
                if (op == 2'b00) v.c3 = 1'b1; else v.c4 = 1'b1;
                trace.push_back(v); k++;
            end else if (op == 2'b10) begin
                // Booth: one test cycle then one shift cycle per bit.
                for (int i = 0; i < W; i++) begin
                    cnt = CW'(i);
                    v = '0; v.busy = 1'b1; v.cnt = cnt;
                    if (tq0[k] == 1'b1 && tq1[k] == 1'b0) v.c4 = 1'b1;
                    if (tq0[k] == 1'b0 && tq1[k] == 1'b1) v.c3 = 1'b1;
                    trace.push_back(v); k++;
                    v = '0; v.busy = 1'b1; v.c5 = 1'b1; v.cnt = cnt;
                    trace.push_back(v); k++;
                end
            end else begin
                // Non-restoring divide: shift, add/sub by old sign, set quotient bit.
                for (int i = 0; i < W; i++) begin
                    cnt = CW'(i);
                    v = '0; v.busy = 1'b1; v.c6 = 1'b1; v.cnt = cnt;
                    sgn = tam[k];
                    trace.push_back(v); k++;
                    v = '0; v.busy = 1'b1; v.cnt = cnt;
                    if (sgn) v.c3 = 1'b1; else v.c4 = 1'b1;
                    trace.push_back(v); k++;
                    v = '0; v.busy = 1'b1; v.c9 = 1'b1; v.qbit = ~tam[k]; v.cnt = cnt;
                    trace.push_back(v); k++;
                end
                v = '0; v.busy = 1'b1; v.c3 = tam[k]; v.cnt = cnt;
                trace.push_back(v); k++;
            end
            v = '0; v.busy = 1'b1; v.c7 = 1'b1; v.cnt = cnt;
            trace.push_back(v); k++;
            if (op[1]) begin
                v = '0; v.busy = 1'b1; v.c8 = 1'b1; v.cnt = cnt;
                trace.push_back(v); k++;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            v = '0; v.done = 1'b1; v.err = dz; v.cnt = cnt;
            trace.push_back(v);
        end
        model_cnt = cnt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic randomize_inputs();
        for (int i = 0; i < NC; i++) begin
            tq0[i] = 1'($urandom_range(0, 1));
            tq1[i] = 1'($urandom_range(0, 1));
            tam[i] = 1'($urandom_range(0, 1));
            tmz[i] = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Runs one operation; abort_at>0 stops driving after that many cycles.
    task automatic run_op(input logic [1:0] op, input int hold, input int abort_at);
        int n;
        build_trace(op, hold);
        n = (abort_at > 0) ? abort_at : trace.size();
        for (int k = 0; k < n; k++) exp_q.push_back(trace[k]);
        @(posedge CLK); #1;
        BGN = 1'b1;
        OP  = op;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            Q0     = tq0[k];
            Q_1    = tq1[k];
            A_MSB  = tam[k];
            M_ZERO = tmz[k];
            OP     = 2'($urandom_range(0, 3));
            if (trace[k].done) BGN = (k != n - 1);
            else               BGN = 1'($urandom_range(0, 1));
        end
        if (abort_at == 0) begin
            @(posedge CLK); #1;
            BGN = 1'b0;
        end
    endtask

    task automatic check_reset(input string name);
        vec_t got;
        got = sample();
        vectors++;
        if (got !== vec_t'(0)) begin
            miscompares++;
            $display("FAIL %s outputs: got %h want %h", name, got, vec_t'(0));
        end
        vectors++;
        if (CNT !== '0) begin
            miscompares++;
            $display("FAIL %s cnt: got %0d want 0", name, CNT);
        end
    endtask

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        vec_t got;
        vec_t want;
        if (RST === 1'b1 && (BUSY === 1'b1 || END === 1'b1)) begin
            got = sample();
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output @%0t: got %h want none", $time, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL cycle_vector @%0t: got %h want %h (op_state %0d)",
                             $time, got, want, state_dbg);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached, %0d expected left", exp_q.size());
        report();
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        model_cnt   = '0;
        RST = 1'b1; BGN = 1'b0; OP = 2'b00;
        Q0 = 1'b0; Q_1 = 1'b0; A_MSB = 1'b0; M_ZERO = 1'b0;
        #1 RST = 1'b0;
        #1 check_reset("power_on_reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1 RST = 1'b1;

        // Directed ADD and SUB with a short DONE hold.
        randomize_inputs();
        run_op(2'b00, 2, 0);
        randomize_inputs();
        run_op(2'b01, 1, 0);

        // Directed MUL: Booth pairs cycle through 10, 01, 11, 00.
        randomize_inputs();
        for (int i = 0; i < W; i++) begin
            case (i % 4)
                0:       begin tq0[2 + 2 * i] = 1'b1; tq1[2 + 2 * i] = 1'b0; end
                1:       begin tq0[2 + 2 * i] = 1'b0; tq1[2 + 2 * i] = 1'b1; end
                2:       begin tq0[2 + 2 * i] = 1'b1; tq1[2 + 2 * i] = 1'b1; end
                default: begin tq0[2 + 2 * i] = 1'b0; tq1[2 + 2 * i] = 1'b0; end
            endcase
        end
        run_op(2'b10, 0, 0);

        // Directed DIV, with BGN held 200ns past DONE entry.
        randomize_inputs();
        tmz[1]          = 1'b0;
        tam[2]          = 1'b0;
        tam[4]          = 1'b1;
        tam[2 + 3 * W]  = 1'b1;
        run_op(2'b11, 20, 0);

        // Reset in the middle of a MUL at CNT=4, then a full MUL run.
        randomize_inputs();
        run_op(2'b10, 0, 10);
        @(posedge CLK); #1;
        vectors++;
        if (CNT !== CW'(4)) begin
            miscompares++;
            $display("FAIL cnt_before_abort: got %0d want 4", CNT);
        end
        #1 RST = 1'b0;
        #1 check_reset("reset_mid_mul");
        @(negedge CLK); #1;
        RST       = 1'b1;
        BGN       = 1'b0;
        model_cnt = '0;
        randomize_inputs();
        run_op(2'b10, 1, 0);

        // Divide by zero (early exit only when the feature is built in).
        randomize_inputs();
        tmz[1] = 1'b1;
        run_op(2'b11, 2, 0);

        // Random operations, holds and datapath status bits.
        for (int t = 0; t < 30; t++) begin
            randomize_inputs();
            run_op(2'($urandom_range(0, 3)), $urandom_range(0, 3), 0);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end

        repeat (3) @(posedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected: got %0d entries left want 0", exp_q.size());
        end
        report();
        $finish;
    end

endmodule
